dmem_port_arbiter: RTL

// - Shares the single-port data memory between two requesters: port 0 (pipeline MEM stage) and port 1 (debug/loader).
// - Sits between the requesters and the data memory. Issues at most one access per cycle and registers the response.
// - Rejects misaligned or illegal accesses before they reach memory.

---
 rtl/dmem_arb_pkg.sv | 36 +++
 rtl/dmem_access_check.sv | 18 +
 rtl/dmem_port_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and decode helpers for the data-memory port arbiter.
// Latency: none (types, constants and a pure function).
// Backpressure: not applicable.
package dmem_arb_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE1 = 1'b1
    } arb_state_t;

    // Legal = funct3 encodes a real RV32 load/store and the address is naturally aligned.
    function automatic logic is_legal(input logic write, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
        logic ok_f3;
        logic ok_al;
        if (write) begin
            ok_f3 = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            ok_f3 = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        case (funct3)
            F3_H, F3_HU: ok_al = ~addr_lo[0];
            F3_W:        ok_al = (addr_lo == 2'b00);
            default:     ok_al = 1'b1;
        endcase
        return ok_f3 && ok_al;
    endfunction

endpackage

// File: rtl/dmem_access_check.sv
// Combinational legality decode for one load/store request.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is valid whenever its inputs are.
module dmem_access_check
    import dmem_arb_pkg::*;
(
    input  logic       write_i,
    input  logic [2:0] funct3_i,
    input  logic [1:0] addr_lo_i,
    output logic       legal_o
);

    // Single shared decode so the trap logic and the arbiter can never disagree.
    always_comb begin
        legal_o = is_legal(write_i, funct3_i, addr_lo_i);
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port data memory, with legality filtering.
// Latency: grant is combinational; the response is registered and appears 1 cycle after accept.
// Backpressure: pXReady is the grant; p0 has priority except when p1 has waited STARVE_LIMIT cycles.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0Valid,
    output logic        p0Ready,
    input  logic        p0Write,
    input  logic [2:0]  p0Funct3,
    input  logic [31:0] p0Addr,
    input  logic [31:0] p0WData,
    output logic        p0RValid,
    output logic [31:0] p0RData,
    output logic        p0Err,
    input  logic        p1Valid,
    output logic        p1Ready,
    input  logic        p1Write,
    input  logic [2:0]  p1Funct3,
    input  logic [31:0] p1Addr,
    input  logic [31:0] p1WData,
    output logic        p1RValid,
    output logic [31:0] p1RData,
    output logic        p1Err,
    output logic [31:0] memAddress,
    output logic        memReadMemory,
    output logic        memWriteMemory,
    output logic [2:0]  memFunct3,
    output logic [31:0] memWriteData,
    input  logic [31:0] memReadData
);

    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             gnt0, gnt1, any_gnt, legal, go;
    logic             sel_write;
    logic [2:0]       sel_funct3;
    logic [31:0]      sel_addr, sel_wdata, resp_data;
    logic             p0_rvld_q, p0_err_q, p1_rvld_q, p1_err_q;
    logic [31:0]      p0_rdat_q, p1_rdat_q;

    // Grant: p0 first in NORMAL, p1 first in FORCE1; at most one winner per cycle.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == FORCE1) begin
            if (p1Valid)      gnt1 = 1'b1;
            else if (p0Valid) gnt0 = 1'b1;
        end else begin
            if (p0Valid)      gnt0 = 1'b1;
            else if (p1Valid) gnt1 = 1'b1;
        end
    end

    assign p0Ready    = gnt0;
    assign p1Ready    = gnt1;
    assign any_gnt    = gnt0 | gnt1;
    assign sel_write  = gnt1 ? p1Write  : p0Write;
    assign sel_funct3 = gnt1 ? p1Funct3 : p0Funct3;
    assign sel_addr   = gnt1 ? p1Addr   : p0Addr;
    assign sel_wdata  = gnt1 ? p1WData  : p0WData;

    dmem_access_check u_check (
        .write_i   (sel_write),
        .funct3_i  (sel_funct3),
        .addr_lo_i (sel_addr[1:0]),
        .legal_o   (legal)
    );

    assign go = any_gnt & legal;

    // Memory side sees nothing at all unless a legal request won this cycle.
    always_comb begin
        memAddress     = '0;
        memReadMemory  = 1'b0;
        memWriteMemory = 1'b0;
        memFunct3      = '0;
        memWriteData   = '0;
        if (go) begin
            memAddress     = sel_addr;
            memReadMemory  = ~sel_write;
            memWriteMemory = sel_write;
            memFunct3      = sel_funct3;
            memWriteData   = sel_wdata;
        end
    end

    // Starve counter and FSM next state; FORCE1 always lasts one cycle since it either grants or idles.
    always_comb begin
        starve_d = starve_q;
        state_d  = state_q;
        if (!p1Valid || gnt1) begin
            starve_d = '0;
        end else if (starve_q != {CNT_W{1'b1}}) begin
            starve_d = starve_q + 1'b1;
        end
        case (state_q)
            NORMAL:  if (starve_d == LIMIT_CNT) state_d = FORCE1;
            FORCE1:  state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= NORMAL;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Stores and rejected requests return zero data; loads return the memory word.
    assign resp_data = (legal && !sel_write) ? memReadData : 32'h0;

    // Response registers: only the winner's data/err update; both valids pulse for one cycle only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p0_rvld_q <= 1'b0;
            p0_rdat_q <= '0;
            p0_err_q  <= 1'b0;
            p1_rvld_q <= 1'b0;
            p1_rdat_q <= '0;
            p1_err_q  <= 1'b0;
        end else begin
            p0_rvld_q <= gnt0;
            p1_rvld_q <= gnt1;
            if (gnt0) begin
                p0_rdat_q <= resp_data;
                p0_err_q  <= ~legal;
            end
            if (gnt1) begin
                p1_rdat_q <= resp_data;
                p1_err_q  <= ~legal;
            end
        end
    end

    assign p0RValid = p0_rvld_q;
    assign p0RData  = p0_rdat_q;
    assign p0Err    = p0_err_q;
    assign p1RValid = p1_rvld_q;
    assign p1RData  = p1_rdat_q;
    assign p1Err    = p1_err_q;

endmodule
